// File: rtl/dac_wave_gen.sv
// dac_wave_gen: FIFO-fed 8-bit DAC playback engine paced by a 1 us tick.
// Ports:
//   mclk, reset_n                 clock, asynchronous active-low reset
//   reg_cs/wr/addr/wdata/be       register bus request (addr[3:2] decoded)
//   reg_rdata, reg_ack            registered read data and one-cycle ack
//   pulse1m_mclk                  one-cycle 1 us tick
//   dac_code, dac_update          DAC code and new-sample strobe
//   irq                           level interrupt (low watermark or underflow)
module dac_wave_gen #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        mclk,
    input  logic        reset_n,
    input  logic        reg_cs,
    input  logic        reg_wr,
    input  logic [7:0]  reg_addr,
    input  logic [31:0] reg_wdata,
    input  logic [3:0]  reg_be,
    output logic [31:0] reg_rdata,
    output logic        reg_ack,
    input  logic        pulse1m_mclk,
    output logic [7:0]  dac_code,
    output logic        dac_update,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_SAMPLE = 2'd2;

    logic [7:0]  r_mem [FIFO_DEPTH];
    logic [AW:0] r_wp, r_rp;
    logic        r_en, r_unf, r_ovf;
    logic [7:0]  r_rate, r_idle_code, r_cnt;
    logic [3:0]  r_low_wm;
    logic [1:0]  r_state;

    logic        w_acc, w_wr, w_rd, w_ctrl_wr, w_data_wr, w_stat_wr, w_idle_wr;
    logic        w_en_nxt, w_flush, w_empty, w_full;
    logic        w_pop_req, w_pop, w_unf_set, w_push_req, w_push, w_ovf_set;
    logic        w_unf_clr, w_ovf_clr, w_unused;
    logic [7:0]  w_rate_nxt, w_reload;
    logic [AW:0] w_level;
    logic [4:0]  w_level5;
    logic [31:0] w_ctrl, w_status, w_rd_data;

    assign w_acc     = reg_cs & ~reg_ack;
    assign w_wr      = w_acc & reg_wr;
    assign w_rd      = w_acc & ~reg_wr;
    assign w_ctrl_wr = w_wr & (reg_addr[3:2] == 2'd0);
    assign w_data_wr = w_wr & (reg_addr[3:2] == 2'd1);
    assign w_stat_wr = w_wr & (reg_addr[3:2] == 2'd2);
    assign w_idle_wr = w_wr & (reg_addr[3:2] == 2'd3);

    // Post-write EN/RATE so that enabling, disabling and reloads act in the write cycle itself
    assign w_en_nxt   = (w_ctrl_wr & reg_be[0]) ? reg_wdata[0] : r_en;
    assign w_rate_nxt = (w_ctrl_wr & reg_be[1]) ? reg_wdata[15:8] : r_rate;
    assign w_reload   = (w_rate_nxt == 8'd0) ? 8'd1 : w_rate_nxt;
    assign w_flush    = w_ctrl_wr & reg_be[0] & reg_wdata[1];

    assign w_level  = r_wp - r_rp;
    assign w_level5 = 5'(w_level);
    assign w_empty  = (r_wp == r_rp);
    assign w_full   = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);

    // Flush overrides both FIFO ports and suppresses the sticky error flags
    assign w_pop_req  = (r_state == S_SAMPLE) & w_en_nxt;
    assign w_pop      = w_pop_req & ~w_empty & ~w_flush;
    assign w_unf_set  = w_pop_req & w_empty & ~w_flush;
    assign w_push_req = w_data_wr & reg_be[0];
    assign w_push     = w_push_req & ~w_flush & (~w_full | w_pop);
    assign w_ovf_set  = w_push_req & ~w_flush & w_full & ~w_pop;
    assign w_unf_clr  = w_stat_wr & reg_be[0] & reg_wdata[2];
    assign w_ovf_clr  = w_stat_wr & reg_be[0] & reg_wdata[3];

    assign w_ctrl    = {12'd0, r_low_wm, r_rate, 7'd0, r_en};
    assign w_status  = {19'd0, w_level5, 4'd0, r_ovf, r_unf, w_full, w_empty};
    assign w_rd_data = (reg_addr[3:2] == 2'd0) ? w_ctrl :
                       (reg_addr[3:2] == 2'd2) ? w_status :
                       (reg_addr[3:2] == 2'd3) ? {24'd0, r_idle_code} : 32'd0;
    assign w_unused  = ^{reg_addr[7:4], reg_addr[1:0], reg_wdata[31:20]};

    always_ff @(posedge mclk) begin
        if (w_push) r_mem[r_wp[AW-1:0]] <= reg_wdata[7:0];
    end

    // Counter reaching 0 moves to SAMPLE on the following cycle; SAMPLE reloads
    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
        end else if (!w_en_nxt) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
        end else if (r_state == S_IDLE || r_state == S_SAMPLE) begin
            r_state <= S_RUN;
            r_cnt   <= w_reload;
        end else if (r_cnt == 8'd0) begin
            r_state <= S_SAMPLE;
        end else if (pulse1m_mclk) begin
            r_cnt   <= r_cnt - 8'd1;
        end
    end

    always_ff @(posedge mclk or negedge reset_n) begin
        if (!reset_n) begin
            r_wp        <= '0;
            r_rp        <= '0;
            r_en        <= 1'b0;
            r_rate      <= 8'd0;
            r_low_wm    <= 4'd0;
            r_idle_code <= 8'h80;
            r_unf       <= 1'b0;
            r_ovf       <= 1'b0;
            dac_code    <= 8'h80;
            dac_update  <= 1'b0;
            irq         <= 1'b0;
            reg_ack     <= 1'b0;
            reg_rdata   <= 32'd0;
        end else begin
            r_wp        <= w_flush ? '0 : r_wp + {{AW{1'b0}}, w_push};
            r_rp        <= w_flush ? '0 : r_rp + {{AW{1'b0}}, w_pop};
            r_en        <= w_en_nxt;
            r_rate      <= w_rate_nxt;
            r_low_wm    <= (w_ctrl_wr & reg_be[2]) ? reg_wdata[19:16] : r_low_wm;
            r_idle_code <= (w_idle_wr & reg_be[0]) ? reg_wdata[7:0] : r_idle_code;
            r_unf       <= w_unf_set | (r_unf & ~w_unf_clr);
            r_ovf       <= w_ovf_set | (r_ovf & ~w_ovf_clr);
            dac_code    <= (r_state == S_IDLE) ? r_idle_code : w_pop ? r_mem[r_rp[AW-1:0]] : dac_code;
            dac_update  <= w_pop;
            irq         <= r_en & ((w_level5 <= {1'b0, r_low_wm}) | r_unf);
            reg_ack     <= w_acc;
            reg_rdata   <= w_rd ? w_rd_data : 32'd0;
        end
    end
endmodule

// File: tb/tb_dac_wave_gen.sv
// tb_dac_wave_gen: randomized scenario bench for dac_wave_gen with a queue-based reference model.
module tb_dac_wave_gen;
    logic        mclk = 1'b0, reset_n = 1'b0, reg_cs = 1'b0, reg_wr = 1'b0;
    logic [7:0]  reg_addr = 8'd0;
    logic [31:0] reg_wdata = 32'd0;
    logic [3:0]  reg_be = 4'd0;
    logic [31:0] reg_rdata;
    logic        reg_ack;
    logic        pulse1m_mclk = 1'b0;
    logic [7:0]  dac_code;
    logic        dac_update, irq;

    int tests = 0, fails = 0;
    logic [7:0] model_q[$];
    logic [7:0] got_code[$];
    int         got_gap[$];

    dac_wave_gen #(.FIFO_DEPTH(8)) dut (
        .mclk(mclk), .reset_n(reset_n), .reg_cs(reg_cs), .reg_wr(reg_wr),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_be(reg_be),
        .reg_rdata(reg_rdata), .reg_ack(reg_ack), .pulse1m_mclk(pulse1m_mclk),
        .dac_code(dac_code), .dac_update(dac_update), .irq(irq)
    );

    always #5 mclk = ~mclk;

    // 1 us tick: one cycle high out of every ten
    initial begin
        forever begin
            repeat (9) @(posedge mclk);
            #1 pulse1m_mclk = 1'b1;
            @(posedge mclk);
            #1 pulse1m_mclk = 1'b0;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge mclk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        reg_cs = 1'b1; reg_wr = 1'b1; reg_addr = a; reg_wdata = d; reg_be = be;
        cyc(1);
        reg_cs = 1'b0; reg_wr = 1'b0;
        cyc(1);
    endtask

    task automatic bus_read(input logic [7:0] a, output logic [31:0] d, output logic ack);
        reg_cs = 1'b1; reg_wr = 1'b0; reg_addr = a;
        cyc(1);
        d = reg_rdata; ack = reg_ack;
        reg_cs = 1'b0;
        cyc(1);
    endtask

    task automatic push(input logic [7:0] v);
        bus_write(8'h04, {24'd0, v}, 4'h1);
        if (model_q.size() < 8) model_q.push_back(v);
    endtask

    function automatic logic [31:0] ctrl_word(input int wm, input int rate, input bit fl, input bit en);
        return {12'd0, 4'(wm), 8'(rate), 6'd0, fl, en};
    endfunction

    task automatic do_reset();
        reset_n = 1'b0;
        cyc(3);
        reset_n = 1'b1;
        cyc(1);
        model_q.delete();
    endtask

    task automatic play(input int n, input int rate);
        int last = 0;
        got_code.delete();
        got_gap.delete();
        for (int c = 1; c <= (n + 2) * rate * 10 + 50 && got_code.size() < n; c++) begin
            cyc(1);
            if (dac_update) begin
                got_code.push_back(dac_code);
                got_gap.push_back(c - last);
                last = c;
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic        a;
        logic [7:0]  v;
        reset_n = 1'b0;
        cyc(2);
        tests++; if (dac_code !== 8'h80) begin fails++; $display("FAIL reset_dac_code got %h expected 80", dac_code); end
        tests++; if (reg_ack !== 1'b0) begin fails++; $display("FAIL reset_ack got %b expected 0", reg_ack); end
        tests++; if (reg_rdata !== 32'd0) begin fails++; $display("FAIL reset_rdata got %h expected 0", reg_rdata); end
        tests++; if (dac_update !== 1'b0) begin fails++; $display("FAIL reset_update got %b expected 0", dac_update); end
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL reset_irq got %b expected 0", irq); end
        reset_n = 1'b1;
        cyc(1);
        bus_read(8'h00, d, a);
        tests++; if (a !== 1'b1) begin fails++; $display("FAIL read_ack got %b expected 1", a); end
        tests++; if (d !== 32'd0) begin fails++; $display("FAIL reset_ctrl got %h expected 0", d); end
        tests++; if (reg_rdata !== 32'd0) begin fails++; $display("FAIL rdata_idle got %h expected 0", reg_rdata); end
        bus_read(8'h08, d, a);
        tests++; if (d !== 32'h001) begin fails++; $display("FAIL reset_status got %h expected 00000001", d); end
        bus_read(8'h0C, d, a);
        tests++; if (d !== 32'h80) begin fails++; $display("FAIL reset_idle got %h expected 00000080", d); end
        bus_read(8'h04, d, a);
        tests++; if (d !== 32'd0) begin fails++; $display("FAIL data_read got %h expected 0", d); end
        for (int i = 0; i < 4; i++) begin
            v = (i == 0) ? 8'h3C : 8'($urandom_range(0, 255));
            bus_write(8'h0C, {24'($urandom), v}, 4'h1);
            tests++; if (dac_code !== v) begin fails++; $display("FAIL idle_to_dac got %h expected %h", dac_code, v); end
            bus_write(8'h0C, 32'($urandom), 4'h0);
            bus_read(8'h0C, d, a);
            tests++; if (d !== {24'd0, v}) begin fails++; $display("FAIL idle_be0 got %h expected %h", d, v); end
        end
        bus_write(8'h00, 32'hFFFF_FF00, 4'b0010);
        bus_read(8'h00, d, a);
        tests++; if (d !== 32'h0000_FF00) begin fails++; $display("FAIL ctrl_be got %h expected 0000ff00", d); end
    endtask

    task automatic test_playback(input bit fixed);
        logic [31:0] d;
        logic        a;
        logic [7:0]  last;
        int rate, eff, n, extra;
        do_reset();
        rate = fixed ? 4 : $urandom_range(0, 5);
        eff  = (rate == 0) ? 1 : rate;
        n    = fixed ? 3 : $urandom_range(1, 8);
        for (int i = 0; i < n; i++) push(fixed ? 8'(16 * (i + 1)) : 8'($urandom_range(0, 255)));
        bus_write(8'h00, ctrl_word(0, rate, 0, 1), 4'hF);
        play(n, eff);
        tests++; if (got_code.size() !== n) begin fails++; $display("FAIL play_count got %0d expected %0d", got_code.size(), n); end
        last = 8'h80;
        for (int i = 0; i < got_code.size(); i++) begin
            last = model_q.pop_front();
            tests++; if (got_code[i] !== last) begin fails++; $display("FAIL play_code[%0d] got %h expected %h", i, got_code[i], last); end
            if (i == 0) begin
                tests++; if (got_gap[0] < (eff - 1) * 10 + 1 || got_gap[0] > eff * 10 + 2) begin fails++; $display("FAIL first_delay got %0d expected %0d..%0d", got_gap[0], (eff - 1) * 10 + 1, eff * 10 + 2); end
            end else begin
                tests++; if (got_gap[i] !== eff * 10) begin fails++; $display("FAIL play_period[%0d] got %0d expected %0d", i, got_gap[i], eff * 10); end
            end
        end
        extra = 0;
        for (int i = 0; i < eff * 10 + 5; i++) begin
            cyc(1);
            if (dac_update) extra++;
        end
        tests++; if (extra !== 0) begin fails++; $display("FAIL unf_update got %0d expected 0", extra); end
        tests++; if (dac_code !== last) begin fails++; $display("FAIL unf_hold got %h expected %h", dac_code, last); end
        bus_read(8'h08, d, a);
        tests++; if (d !== 32'h005) begin fails++; $display("FAIL unf_status got %h expected 00000005", d); end
        tests++; if (irq !== 1'b1) begin fails++; $display("FAIL unf_irq got %b expected 1", irq); end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        logic        a;
        do_reset();
        for (int i = 0; i < 9; i++) push(8'($urandom_range(0, 255)));
        bus_read(8'h08, d, a);
        tests++; if (d !== 32'h80A) begin fails++; $display("FAIL ovf_status got %h expected 0000080a", d); end
        bus_write(8'h08, 32'h8, 4'h1);
        bus_read(8'h08, d, a);
        tests++; if (d !== 32'h802) begin fails++; $display("FAIL ovf_w1c got %h expected 00000802", d); end
        bus_write(8'h00, ctrl_word(0, 1, 0, 1), 4'hF);
        play(9, 1);
        tests++; if (got_code.size() !== 8) begin fails++; $display("FAIL ovf_play_count got %0d expected 8", got_code.size()); end
        for (int i = 0; i < got_code.size() && model_q.size() > 0; i++) begin
            tests++; if (got_code[i] !== model_q[0]) begin fails++; $display("FAIL ovf_code[%0d] got %h expected %h", i, got_code[i], model_q[0]); end
            void'(model_q.pop_front());
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic        a;
        logic [7:0]  v;
        do_reset();
        for (int i = 0; i < 8; i++) push(8'($urandom_range(0, 255)));
        bus_write(8'h00, ctrl_word(0, 1, 0, 1), 4'hF);
        play(1, 1);
        tests++; if (got_code.size() !== 1 || got_code[0] !== model_q[0]) begin fails++; $display("FAIL col_first got %0d samples expected 1 of %h", got_code.size(), model_q[0]); end
        void'(model_q.pop_front());
        push(8'($urandom_range(0, 255)));
        cyc(7);
        v = 8'($urandom_range(0, 255));
        reg_cs = 1'b1; reg_wr = 1'b1; reg_addr = 8'h04; reg_wdata = {24'd0, v}; reg_be = 4'h1;
        cyc(1);
        reg_cs = 1'b0; reg_wr = 1'b0;
        tests++; if (dac_update !== 1'b1) begin fails++; $display("FAIL col_align got %b expected 1", dac_update); end
        tests++; if (dac_code !== model_q[0]) begin fails++; $display("FAIL col_pop got %h expected %h", dac_code, model_q[0]); end
        void'(model_q.pop_front());
        model_q.push_back(v);
        cyc(1);
        bus_read(8'h08, d, a);
        tests++; if (d !== 32'h802) begin fails++; $display("FAIL col_status got %h expected 00000802", d); end
        play(8, 1);
        tests++; if (got_code.size() !== 8) begin fails++; $display("FAIL col_play_count got %0d expected 8", got_code.size()); end
        for (int i = 0; i < got_code.size() && model_q.size() > 0; i++) begin
            tests++; if (got_code[i] !== model_q[0]) begin fails++; $display("FAIL col_code[%0d] got %h expected %h", i, got_code[i], model_q[0]); end
            void'(model_q.pop_front());
        end
    endtask

    task automatic test_flush_disable();
        logic [31:0] d;
        logic        a;
        logic [7:0]  idle;
        int rate, n;
        do_reset();
        idle = 8'($urandom_range(0, 255));
        bus_write(8'h0C, {24'd0, idle}, 4'h1);
        rate = $urandom_range(2, 3);
        for (int i = 0; i < 5; i++) push(8'($urandom_range(0, 255)));
        bus_write(8'h00, ctrl_word(2, rate, 0, 1), 4'hF);
        play(2, rate);
        for (int i = 0; i < 2; i++) begin
            tests++; if (got_code.size() <= i || got_code[i] !== model_q[i]) begin fails++; $display("FAIL flush_play[%0d] got %0d samples expected code %h", i, got_code.size(), model_q[i]); end
        end
        bus_write(8'h00, ctrl_word(2, rate, 1, 1), 4'hF);
        model_q.delete();
        bus_read(8'h08, d, a);
        tests++; if (d !== 32'h001) begin fails++; $display("FAIL flush_status got %h expected 00000001", d); end
        bus_read(8'h00, d, a);
        tests++; if (d !== ctrl_word(2, rate, 0, 1)) begin fails++; $display("FAIL flush_selfclr got %h expected %h", d, ctrl_word(2, rate, 0, 1)); end
        tests++; if (irq !== 1'b1) begin fails++; $display("FAIL flush_irq got %b expected 1", irq); end
        bus_write(8'h00, ctrl_word(2, rate, 0, 0), 4'hF);
        tests++; if (dac_code !== idle) begin fails++; $display("FAIL disable_idle got %h expected %h", dac_code, idle); end
        n = 0;
        for (int i = 0; i < rate * 50; i++) begin
            cyc(1);
            if (dac_update || dac_code !== idle) n++;
        end
        tests++; if (n !== 0) begin fails++; $display("FAIL disable_quiet got %0d events expected 0", n); end
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL disable_irq got %b expected 0", irq); end
    endtask

    task automatic test_async_reset();
        logic [31:0] d;
        logic        a;
        do_reset();
        for (int i = 0; i < 4; i++) push(8'($urandom_range(0, 127)));
        bus_write(8'h00, ctrl_word(15, 2, 0, 1), 4'hF);
        play(1, 2);
        cyc(3);
        tests++; if (irq !== 1'b1) begin fails++; $display("FAIL pre_reset_irq got %b expected 1", irq); end
        reset_n = 1'b0;
        #2;
        tests++; if (dac_code !== 8'h80) begin fails++; $display("FAIL areset_dac got %h expected 80", dac_code); end
        tests++; if (irq !== 1'b0) begin fails++; $display("FAIL areset_irq got %b expected 0", irq); end
        tests++; if (dac_update !== 1'b0 || reg_ack !== 1'b0 || reg_rdata !== 32'd0) begin fails++; $display("FAIL areset_bus got upd=%b ack=%b rdata=%h expected 0", dac_update, reg_ack, reg_rdata); end
        @(posedge mclk);
        #1 reset_n = 1'b1;
        cyc(1);
        model_q.delete();
        bus_read(8'h08, d, a);
        tests++; if (d !== 32'h001) begin fails++; $display("FAIL areset_status got %h expected 00000001", d); end
        bus_read(8'h00, d, a);
        tests++; if (d !== 32'd0) begin fails++; $display("FAIL areset_ctrl got %h expected 0", d); end
    endtask

    initial begin
        cyc(1);
        test_reset();
        test_playback(1'b1);
        for (int i = 0; i < 3; i++) test_playback(1'b0);
        test_overflow();
        test_back_to_back();
        test_flush_disable();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
